// File: rtl/gram_readout_if.sv
// Output stream of the Gram-matrix readout: one matrix entry per handshake,
// tagged with its row/column position and an end-of-matrix marker.
`timescale 1ns/1ps

interface gram_readout_if #(
    parameter int ACC_W = 32
) ();
    // Handshake: an entry transfers on a rising clk edge where m_valid && m_ready.
    // The master holds m_valid, m_data, m_row, m_col and m_last stable until that
    // transfer, and never withdraws m_valid without one.
    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_data;
    logic [1:0]       m_row;
    logic [1:0]       m_col;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_row,
        output m_col,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/gram_readout.sv
// Readout of a 3x3 Gram-matrix systolic array: captures the six lower-triangular
// PE results and streams them (optionally mirrored to the full matrix) over m.
`timescale 1ns/1ps

module gram_readout #(
    parameter int DIMENSION = 4,
    parameter int WIDTH     = 8,
    parameter int ACC_W     = DIMENSION * WIDTH,
    parameter bit FULL      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [ACC_W-1:0] P11,
    input  logic [ACC_W-1:0] P21,
    input  logic [ACC_W-1:0] P22,
    input  logic [ACC_W-1:0] P31,
    input  logic [ACC_W-1:0] P32,
    input  logic [ACC_W-1:0] P33,
    input  logic             clr_ovf,
    gram_readout_if.master   m,
    output logic             busy,
    output logic             ovf,
    output logic             dbg_state,
    output logic [3:0]       dbg_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int         N_ENT    = FULL ? 9 : 6;
    localparam logic [3:0] LAST_IDX = 4'(N_ENT - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [ACC_W-1:0] p_q [6];
    logic [ACC_W-1:0] p_d [6];
    logic             ovf_q, ovf_d;
    logic             m_valid_q, m_valid_d;
    logic [ACC_W-1:0] m_data_q, m_data_d;
    logic [1:0]       m_row_q, m_row_d;
    logic [1:0]       m_col_q, m_col_d;
    logic             m_last_q, m_last_d;

    logic             hs;
    logic             at_last;
    logic             load;
    logic [2:0]       sel_k;
    logic [1:0]       sel_row;
    logic [1:0]       sel_col;

    assign hs      = m_valid_q && m.m_ready;
    assign at_last = (idx_q == LAST_IDX);

    // Next state, index, capture registers and sticky overrun flag.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (at_last) begin
                        if (cap) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            idx_d  = 4'd0;
            p_d[0] = P11;
            p_d[1] = P21;
            p_d[2] = P22;
            p_d[3] = P31;
            p_d[4] = P32;
            p_d[5] = P33;
        end

        // A capture that cannot be taken is dropped; flagging it wins over a clear.
        if ((state_q == SEND) && cap && !(hs && at_last)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Entry table: p index 0..5 = P11 P21 P22 P31 P32 P33; upper entries reuse
    // their lower-triangle mirror (G01=P21, G02=P31, G12=P32).
    always_comb begin
        sel_k   = 3'd0;
        sel_row = 2'd0;
        sel_col = 2'd0;
        if (FULL) begin
            case (idx_d)
                4'd0: begin sel_k = 3'd0; sel_row = 2'd0; sel_col = 2'd0; end
                4'd1: begin sel_k = 3'd1; sel_row = 2'd0; sel_col = 2'd1; end
                4'd2: begin sel_k = 3'd3; sel_row = 2'd0; sel_col = 2'd2; end
                4'd3: begin sel_k = 3'd1; sel_row = 2'd1; sel_col = 2'd0; end
                4'd4: begin sel_k = 3'd2; sel_row = 2'd1; sel_col = 2'd1; end
                4'd5: begin sel_k = 3'd4; sel_row = 2'd1; sel_col = 2'd2; end
                4'd6: begin sel_k = 3'd3; sel_row = 2'd2; sel_col = 2'd0; end
                4'd7: begin sel_k = 3'd4; sel_row = 2'd2; sel_col = 2'd1; end
                4'd8: begin sel_k = 3'd5; sel_row = 2'd2; sel_col = 2'd2; end
                default: begin sel_k = 3'd0; sel_row = 2'd0; sel_col = 2'd0; end
            endcase
        end else begin
            case (idx_d)
                4'd0: begin sel_k = 3'd0; sel_row = 2'd0; sel_col = 2'd0; end
                4'd1: begin sel_k = 3'd1; sel_row = 2'd1; sel_col = 2'd0; end
                4'd2: begin sel_k = 3'd2; sel_row = 2'd1; sel_col = 2'd1; end
                4'd3: begin sel_k = 3'd3; sel_row = 2'd2; sel_col = 2'd0; end
                4'd4: begin sel_k = 3'd4; sel_row = 2'd2; sel_col = 2'd1; end
                4'd5: begin sel_k = 3'd5; sel_row = 2'd2; sel_col = 2'd2; end
                default: begin sel_k = 3'd0; sel_row = 2'd0; sel_col = 2'd0; end
            endcase
        end
    end

    // Outputs are registered from the next-cycle entry, so they only move on a
    // handshake or a fresh capture and read as zero while idle.
    always_comb begin
        m_valid_d = (state_d == SEND);
        m_data_d  = '0;
        m_row_d   = 2'd0;
        m_col_d   = 2'd0;
        m_last_d  = 1'b0;
        if (state_d == SEND) begin
            m_data_d = p_d[sel_k];
            m_row_d  = sel_row;
            m_col_d  = sel_col;
            m_last_d = (idx_d == LAST_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                p_q[i] <= '0;
            end
            ovf_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_row_q   <= 2'd0;
            m_col_q   <= 2'd0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            p_q       <= p_d;
            ovf_q     <= ovf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_row_q   <= m_row_d;
            m_col_q   <= m_col_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m.m_valid = m_valid_q;
    assign m.m_data  = m_data_q;
    assign m.m_row   = m_row_q;
    assign m.m_col   = m_col_q;
    assign m.m_last  = m_last_q;
    assign busy      = (state_q == SEND);
    assign ovf       = ovf_q;
    assign dbg_state = state_q;
    assign dbg_idx   = idx_q;

endmodule

// File: tb/tb_gram_readout.sv
// Directed bench for gram_readout: a FULL=1 instance (dut_a) and a FULL=0
// instance (dut_b) sharing clock, reset and PE inputs.
`timescale 1ns/1ps

module tb_gram_readout;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap_a = 1'b0;
    logic        cap_b = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] p11 = '0, p21 = '0, p22 = '0, p31 = '0, p32 = '0, p33 = '0;
    logic        busy_a, ovf_a, dbg_state_a;
    logic        busy_b, ovf_b, dbg_state_b;
    logic [3:0]  dbg_idx_a, dbg_idx_b;

    int n_cmp = 0;
    int n_err = 0;

    int row_f [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int col_f [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int row_l [6] = '{0, 1, 1, 2, 2, 2};
    int col_l [6] = '{0, 0, 1, 0, 1, 2};

    gram_readout_if #(.ACC_W(32)) ifa ();
    gram_readout_if #(.ACC_W(32)) ifb ();

    gram_readout #(.DIMENSION(4), .WIDTH(8), .ACC_W(32), .FULL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .cap(cap_a),
        .P11(p11), .P21(p21), .P22(p22), .P31(p31), .P32(p32), .P33(p33),
        .clr_ovf(clr_ovf), .m(ifa), .busy(busy_a), .ovf(ovf_a),
        .dbg_state(dbg_state_a), .dbg_idx(dbg_idx_a)
    );

    gram_readout #(.DIMENSION(4), .WIDTH(8), .ACC_W(32), .FULL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .cap(cap_b),
        .P11(p11), .P21(p21), .P22(p22), .P31(p31), .P32(p32), .P33(p33),
        .clr_ovf(clr_ovf), .m(ifb), .busy(busy_b), .ovf(ovf_b),
        .dbg_state(dbg_state_b), .dbg_idx(dbg_idx_b)
    );

    always #5 clk = ~clk;

    task automatic set_p(input int v0, input int v1, input int v2,
                         input int v3, input int v4, input int v5);
        p11 = 32'(v0); p21 = 32'(v1); p22 = 32'(v2);
        p31 = 32'(v3); p32 = 32'(v4); p33 = 32'(v5);
    endtask

    task automatic test_reset();
        rst = 1'b0; cap_a = 1'b1; cap_b = 1'b1;
        ifa.m_ready = 1'b1; ifb.m_ready = 1'b1;
        set_p(1, 2, 3, 4, 5, 6);
        repeat (3) @(negedge clk);
        n_cmp++; if (ifa.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_a: got %b want 0", ifa.m_valid); end
        n_cmp++; if (ifa.m_data !== 32'd0) begin n_err++; $display("FAIL reset_data_a: got %0h want 0", ifa.m_data); end
        n_cmp++; if ({ifa.m_row, ifa.m_col, ifa.m_last} !== 5'd0) begin n_err++; $display("FAIL reset_tags_a: got %b want 00000", {ifa.m_row, ifa.m_col, ifa.m_last}); end
        n_cmp++; if ({busy_a, ovf_a} !== 2'b00) begin n_err++; $display("FAIL reset_busy_ovf_a: got %b want 00", {busy_a, ovf_a}); end
        n_cmp++; if ({ifb.m_valid, busy_b, ovf_b} !== 3'b000) begin n_err++; $display("FAIL reset_b: got %b want 000", {ifb.m_valid, busy_b, ovf_b}); end
        cap_a = 1'b0; cap_b = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ifa.m_valid, busy_a} !== 2'b00) begin n_err++; $display("FAIL reset_release_idle: got %b want 00", {ifa.m_valid, busy_a}); end
    endtask

    task automatic test_full_stream();
        int exp_d [9] = '{1, 2, 4, 2, 3, 5, 4, 5, 6};
        set_p(1, 2, 3, 4, 5, 6);
        cap_a = 1'b1; ifa.m_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            cap_a = 1'b0;
            n_cmp++; if ({ifa.m_valid, busy_a} !== 2'b11) begin n_err++; $display("FAIL full_valid[%0d]: got %b want 11", e, {ifa.m_valid, busy_a}); end
            n_cmp++; if (ifa.m_data !== 32'(exp_d[e])) begin n_err++; $display("FAIL full_data[%0d]: got %0d want %0d", e, ifa.m_data, exp_d[e]); end
            n_cmp++; if ({ifa.m_row, ifa.m_col} !== {2'(row_f[e]), 2'(col_f[e])}) begin n_err++; $display("FAIL full_rowcol[%0d]: got %0d,%0d want %0d,%0d", e, ifa.m_row, ifa.m_col, row_f[e], col_f[e]); end
            n_cmp++; if (ifa.m_last !== (e == 8)) begin n_err++; $display("FAIL full_last[%0d]: got %b want %b", e, ifa.m_last, (e == 8)); end
        end
        @(negedge clk);
        n_cmp++; if ({ifa.m_valid, busy_a} !== 2'b00) begin n_err++; $display("FAIL full_end_idle: got %b want 00", {ifa.m_valid, busy_a}); end
    endtask

    task automatic test_backpressure();
        int exp_d [9] = '{21, 22, 24, 22, 23, 25, 24, 25, 26};
        int pat [3] = '{1, 0, 0};
        int e = 0;
        int cyc = 0;
        set_p(21, 22, 23, 24, 25, 26);
        cap_a = 1'b1; ifa.m_ready = 1'b0;
        while (e < 9 && cyc < 60) begin
            @(negedge clk);
            cap_a = 1'b0;
            n_cmp++; if (ifa.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[c%0d]: got %b want 1", cyc, ifa.m_valid); end
            n_cmp++; if (ifa.m_data !== 32'(exp_d[e])) begin n_err++; $display("FAIL bp_data[c%0d e%0d]: got %0d want %0d", cyc, e, ifa.m_data, exp_d[e]); end
            n_cmp++; if ({ifa.m_row, ifa.m_col, ifa.m_last} !== {2'(row_f[e]), 2'(col_f[e]), (e == 8)}) begin n_err++; $display("FAIL bp_tags[c%0d e%0d]: got %0d,%0d,%b want %0d,%0d,%b", cyc, e, ifa.m_row, ifa.m_col, ifa.m_last, row_f[e], col_f[e], (e == 8)); end
            ifa.m_ready = (pat[cyc % 3] != 0);
            if (ifa.m_ready) e++;
            cyc++;
        end
        n_cmp++; if (e != 9) begin n_err++; $display("FAIL bp_timeout: got %0d entries want 9", e); end
        @(negedge clk);
        n_cmp++; if (ifa.m_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_idle: got %b want 0", ifa.m_valid); end
        ifa.m_ready = 1'b1;
    endtask

    task automatic test_overrun();
        int exp_d [9] = '{1, 2, 4, 2, 3, 5, 4, 5, 6};
        int cnt = 0;
        set_p(1, 2, 3, 4, 5, 6);
        cap_a = 1'b1; ifa.m_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            n_cmp++; if (ifa.m_data !== 32'(exp_d[e])) begin n_err++; $display("FAIL ovr_data[%0d]: got %0d want %0d", e, ifa.m_data, exp_d[e]); end
            n_cmp++; if (ovf_a !== (e >= 4)) begin n_err++; $display("FAIL ovr_flag[%0d]: got %b want %b", e, ovf_a, (e >= 4)); end
            cap_a = (e == 3);
            if (e == 3) set_p(90, 91, 92, 93, 94, 95);
        end
        @(negedge clk);
        n_cmp++; if ({ifa.m_valid, ovf_a} !== 2'b01) begin n_err++; $display("FAIL ovr_sticky: got %b want 01", {ifa.m_valid, ovf_a}); end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", ovf_a); end
        set_p(1, 2, 3, 4, 5, 6);
        cap_a = 1'b1;
        @(negedge clk);
        cap_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cap_a = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        cap_a = 1'b0; clr_ovf = 1'b0;
        n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL ovr_set_beats_clr: got %b want 1", ovf_a); end
        n_cmp++; if ({ifa.m_valid, ifa.m_data} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL ovr_entry3: got %b/%0d want 1/2", ifa.m_valid, ifa.m_data); end
        while (ifa.m_valid === 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++; if (ifa.m_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain_timeout: got %b want 0", ifa.m_valid); end
    endtask

    task automatic test_back_to_back();
        int exp1 [9] = '{1, 2, 4, 2, 3, 5, 4, 5, 6};
        int exp2 [9] = '{10, 11, 13, 11, 12, 14, 13, 14, 15};
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        set_p(1, 2, 3, 4, 5, 6);
        cap_a = 1'b1; ifa.m_ready = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            cap_a = 1'b0;
            n_cmp++; if (ifa.m_data !== 32'(exp1[e])) begin n_err++; $display("FAIL b2b_first[%0d]: got %0d want %0d", e, ifa.m_data, exp1[e]); end
            if (e == 8) begin
                cap_a = 1'b1;
                set_p(10, 11, 12, 13, 14, 15);
            end
        end
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            cap_a = 1'b0;
            n_cmp++; if (ifa.m_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", e, ifa.m_valid); end
            n_cmp++; if (ifa.m_data !== 32'(exp2[e])) begin n_err++; $display("FAIL b2b_second[%0d]: got %0d want %0d", e, ifa.m_data, exp2[e]); end
            n_cmp++; if ({ifa.m_row, ifa.m_col, ifa.m_last} !== {2'(row_f[e]), 2'(col_f[e]), (e == 8)}) begin n_err++; $display("FAIL b2b_tags[%0d]: got %0d,%0d,%b want %0d,%0d,%b", e, ifa.m_row, ifa.m_col, ifa.m_last, row_f[e], col_f[e], (e == 8)); end
        end
        @(negedge clk);
        n_cmp++; if ({ifa.m_valid, ovf_a} !== 2'b00) begin n_err++; $display("FAIL b2b_end: got %b want 00", {ifa.m_valid, ovf_a}); end
    endtask

    task automatic test_lower_and_abort();
        int exp_d [6] = '{1, 2, 3, 4, 5, 6};
        set_p(1, 2, 3, 4, 5, 6);
        cap_b = 1'b1; ifb.m_ready = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            cap_b = 1'b0;
            n_cmp++; if ({ifb.m_valid, busy_b} !== 2'b11) begin n_err++; $display("FAIL low_valid[%0d]: got %b want 11", e, {ifb.m_valid, busy_b}); end
            n_cmp++; if (ifb.m_data !== 32'(exp_d[e])) begin n_err++; $display("FAIL low_data[%0d]: got %0d want %0d", e, ifb.m_data, exp_d[e]); end
            n_cmp++; if ({ifb.m_row, ifb.m_col, ifb.m_last} !== {2'(row_l[e]), 2'(col_l[e]), (e == 5)}) begin n_err++; $display("FAIL low_tags[%0d]: got %0d,%0d,%b want %0d,%0d,%b", e, ifb.m_row, ifb.m_col, ifb.m_last, row_l[e], col_l[e], (e == 5)); end
        end
        @(negedge clk);
        n_cmp++; if ({ifb.m_valid, busy_b} !== 2'b00) begin n_err++; $display("FAIL low_end_idle: got %b want 00", {ifb.m_valid, busy_b}); end
        cap_b = 1'b1;
        @(negedge clk);
        cap_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (ifb.m_data !== 32'd3) begin n_err++; $display("FAIL abort_pre_entry2: got %0d want 3", ifb.m_data); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({ifb.m_valid, busy_b, ifb.m_last} !== 3'b000) begin n_err++; $display("FAIL abort_async: got %b want 000", {ifb.m_valid, busy_b, ifb.m_last}); end
        n_cmp++; if (ifb.m_data !== 32'd0) begin n_err++; $display("FAIL abort_data: got %0d want 0", ifb.m_data); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({ifb.m_valid, busy_b} !== 2'b00) begin n_err++; $display("FAIL abort_no_resume: got %b want 00", {ifb.m_valid, busy_b}); end
    endtask

    initial begin
        ifa.m_ready = 1'b0;
        ifb.m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_stream();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_lower_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
